seq_detect_param: RTL and testbench

Parametrised serial bit-pattern detector. It is the successor to the fixed 4-bit Mealy "1010" LED detector.
- Pattern length is generic; pattern, don't-care mask and overlap mode are runtime-programmable.
- Input is qualified by a valid strobe.
- A registered match pulse, a saturating match counter and an armed flag are provided.
- Sits between a debounced button/serial bit source and LED/status logic.

---
 rtl/seq_detect_pkg.sv | 9 +
 rtl/seq_detect_if.sv | 27 ++
 rtl/seq_sat_counter.sv | 40 ++++
 rtl/seq_detect_param.sv | 102 ++++++++++
 tb/tb_seq_detect_param.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and encodings for the parametrised serial pattern detector.
package seq_detect_pkg;
  localparam int         PAT_LEN_MIN     = 2;
  localparam int         PAT_LEN_MAX     = 32;
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

  typedef enum logic {OVL_OFF = 1'b0, OVL_ON = 1'b1} ovl_e;
  typedef enum logic {FILLING = 1'b0, ARMED = 1'b1} fill_state_e;
endpackage

// File: rtl/seq_detect_if.sv
// Bit stream, configuration and status bundle of the pattern detector.
interface seq_detect_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               i_valid;
  logic               i_bit;
  logic               i_cfg_wr;
  logic [PAT_LEN-1:0] i_cfg_pattern;
  logic [PAT_LEN-1:0] i_cfg_mask;
  logic               i_cfg_overlap;
  logic               i_cnt_clr;
  logic               o_match;
  logic [CNT_W-1:0]   o_match_cnt;
  logic               o_cnt_sat;
  logic               o_armed;

  modport master (
    output i_valid, i_bit, i_cfg_wr, i_cfg_pattern, i_cfg_mask, i_cfg_overlap, i_cnt_clr,
    input  o_match, o_match_cnt, o_cnt_sat, o_armed
  );

  modport slave (
    input  i_valid, i_bit, i_cfg_wr, i_cfg_pattern, i_cfg_mask, i_cfg_overlap, i_cnt_clr,
    output o_match, o_match_cnt, o_cnt_sat, o_armed
  );
endinterface

// File: rtl/seq_sat_counter.sv
// Saturating event counter: a clear wins over the old value, then the increment applies.
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);
  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q;

  // next count: clear-then-increment, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = i_inc ? W'(1) : {W{1'b0}};
    end else if (i_inc && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count and saturation flag registered together
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= {W{1'b0}};
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= &cnt_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_sat = sat_q;
endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with programmable pattern, don't-care mask and overlap mode.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN         = 4,
  parameter logic [PAT_LEN-1:0] DEFAULT_PATTERN = PAT_LEN'(seq_detect_pkg::DEFAULT_PATTERN),
  parameter bit                 DEFAULT_OVERLAP = 1'b1,
  parameter int                 CNT_W           = 8
) (
  input logic         i_clock,
  input logic         i_reset,
  seq_detect_if.slave bus
);
  localparam int FW = $clog2(PAT_LEN + 1);

  generate
    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX || CNT_W < 1) begin : g_bad_param
      $error("seq_detect_param: PAT_LEN must be 2..32 and CNT_W at least 1");
    end
  endgenerate

  logic [PAT_LEN-1:0] hist_q, hist_d, pat_q, pat_d, mask_q, mask_d, hist_n_s;
  logic [FW-1:0]      fill_q, fill_d, fill_n_s;
  ovl_e               ovl_q, ovl_d;
  fill_state_e        state_q, state_d;
  logic               match_q, match_d, hit_s;

  assign hist_n_s = {hist_q[PAT_LEN-2:0], bus.i_bit};
  assign fill_n_s = (fill_q == FW'(PAT_LEN)) ? fill_q : fill_q + FW'(1);
  assign hit_s    = (fill_n_s == FW'(PAT_LEN)) &&
                    (((hist_n_s ^ pat_q) & mask_q) == {PAT_LEN{1'b0}});

  // next-state for history, fill tracker and configuration
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    ovl_d   = ovl_q;
    state_d = state_q;
    match_d = 1'b0;
    if (bus.i_cfg_wr) begin
      pat_d   = bus.i_cfg_pattern;
      mask_d  = bus.i_cfg_mask;
      ovl_d   = ovl_e'(bus.i_cfg_overlap);
      hist_d  = {PAT_LEN{1'b0}};
      fill_d  = {FW{1'b0}};
      state_d = FILLING;
    end else if (bus.i_valid) begin
      hist_d  = hist_n_s;
      fill_d  = fill_n_s;
      match_d = hit_s;
      case (state_q)
        FILLING: state_d = (fill_n_s == FW'(PAT_LEN)) ? ARMED : FILLING;
        ARMED:   state_d = ARMED;
        default: state_d = FILLING;
      endcase
      // non-overlapping mode restarts the window after every hit
      if (hit_s && ovl_q == OVL_OFF) begin
        fill_d  = {FW{1'b0}};
        state_d = FILLING;
      end else begin
        fill_d  = fill_n_s;
      end
    end else begin
      match_d = 1'b0;
    end
  end

  // state register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hist_q  <= {PAT_LEN{1'b0}};
      fill_q  <= {FW{1'b0}};
      pat_q   <= DEFAULT_PATTERN;
      mask_q  <= {PAT_LEN{1'b1}};
      ovl_q   <= ovl_e'(DEFAULT_OVERLAP);
      state_q <= FILLING;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      ovl_q   <= ovl_d;
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  seq_sat_counter #(.W(CNT_W)) u_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_inc   (match_d),
    .i_clr   (bus.i_cnt_clr),
    .o_cnt   (bus.o_match_cnt),
    .o_sat   (bus.o_cnt_sat)
  );

  assign bus.o_match = match_q;
  assign bus.o_armed = (state_q == ARMED);
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default 8-bit-counter detector plus a 2-bit-counter copy for saturation.
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_detect_if #(.PAT_LEN(4), .CNT_W(8)) bus1 ();
  seq_detect_if #(.PAT_LEN(4), .CNT_W(2)) bus2 ();

  seq_detect_param #(.PAT_LEN(4), .CNT_W(8)) dut1 (.i_clock(clk), .i_reset(rst), .bus(bus1));
  seq_detect_param #(.PAT_LEN(4), .CNT_W(2)) dut2 (.i_clock(clk), .i_reset(rst), .bus(bus2));

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send1(input logic b);
    bus1.i_valid = 1'b1; bus1.i_bit = b;
    @(posedge clk); #1;
    bus1.i_valid = 1'b0;
  endtask

  task automatic send2(input logic b);
    bus2.i_valid = 1'b1; bus2.i_bit = b;
    @(posedge clk); #1;
    bus2.i_valid = 1'b0;
  endtask

  task automatic cfg1(input logic [3:0] pat, input logic [3:0] msk, input logic ovl);
    bus1.i_cfg_wr = 1'b1; bus1.i_cfg_pattern = pat; bus1.i_cfg_mask = msk; bus1.i_cfg_overlap = ovl;
    @(posedge clk); #1;
    bus1.i_cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    bus1.i_valid = 1'b1; bus1.i_bit = 1'b1;
    do_reset();
    bus1.i_valid = 1'b0;
    checks++;
    if ({bus1.o_match, bus1.o_cnt_sat, bus1.o_armed} !== 3'b000 || bus1.o_match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset match/sat/armed=%b cnt=%0d expected 000 cnt=0",
               {bus1.o_match, bus1.o_cnt_sat, bus1.o_armed}, bus1.o_match_cnt);
    end
  endtask

  task automatic test_overlap();
    logic [5:0] bits, exp;
    bits = 6'b101010; exp = 6'b000101;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      send1(bits[i]);
      checks++;
      if (bus1.o_match !== exp[i]) begin
        failures++;
        $display("FAIL overlap_match sample=%0d got=%b expected=%b", 6 - i, bus1.o_match, exp[i]);
      end
    end
    checks++;
    if (bus1.o_match_cnt !== 8'd2) begin
      failures++;
      $display("FAIL overlap_count got=%0d expected=2", bus1.o_match_cnt);
    end
  endtask

  task automatic test_nonoverlap();
    logic [7:0] bits, exp;
    bits = 8'b10101010; exp = 8'b00010001;
    do_reset();
    cfg1(4'b1010, 4'b1111, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      send1(bits[i]);
      checks++;
      if (bus1.o_match !== exp[i]) begin
        failures++;
        $display("FAIL nonoverlap_match sample=%0d got=%b expected=%b", 8 - i, bus1.o_match, exp[i]);
      end
      if (i == 4) begin
        checks++;
        if (bus1.o_armed !== 1'b0) begin
          failures++;
          $display("FAIL nonoverlap_armed got=%b expected=0", bus1.o_armed);
        end
      end
    end
    checks++;
    if (bus1.o_match_cnt !== 8'd2) begin
      failures++;
      $display("FAIL nonoverlap_count got=%0d expected=2", bus1.o_match_cnt);
    end
  endtask

  task automatic test_mask();
    do_reset();
    cfg1(4'b1010, 4'b1110, 1'b1);
    send1(1'b1); send1(1'b0); send1(1'b1); send1(1'b1);
    checks++;
    if (bus1.o_match !== 1'b1) begin
      failures++;
      $display("FAIL mask_dontcare got=%b expected=1", bus1.o_match);
    end
    cfg1(4'b1010, 4'b1111, 1'b1);
    send1(1'b1); send1(1'b0); send1(1'b1); send1(1'b1);
    checks++;
    if (bus1.o_match !== 1'b0 || bus1.o_armed !== 1'b1) begin
      failures++;
      $display("FAIL mask_full match/armed=%b%b expected=01", bus1.o_match, bus1.o_armed);
    end
  endtask

  task automatic test_counter_sat();
    logic [11:0] bits;
    int          m;
    logic [1:0]  exp_cnt [5];
    logic        exp_sat [5];
    bits = 12'b101010101010;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_sat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    m = 0;
    do_reset();
    for (int i = 11; i >= 0; i--) begin
      send2(bits[i]);
      if (bus2.o_match === 1'b1 && m < 5) begin
        checks++;
        if (bus2.o_match_cnt !== exp_cnt[m] || bus2.o_cnt_sat !== exp_sat[m]) begin
          failures++;
          $display("FAIL sat_count match=%0d cnt=%0d sat=%b expected cnt=%0d sat=%b",
                   m + 1, bus2.o_match_cnt, bus2.o_cnt_sat, exp_cnt[m], exp_sat[m]);
        end
        m++;
      end
    end
    checks++;
    if (m != 5) begin
      failures++;
      $display("FAIL sat_match_count got=%0d expected=5", m);
    end
    send2(1'b1);
    bus2.i_cnt_clr = 1'b1;
    send2(1'b0);
    bus2.i_cnt_clr = 1'b0;
    checks++;
    if (bus2.o_match !== 1'b1 || bus2.o_match_cnt !== 2'd1 || bus2.o_cnt_sat !== 1'b0) begin
      failures++;
      $display("FAIL clr_with_match match=%b cnt=%0d sat=%b expected 1 1 0",
               bus2.o_match, bus2.o_match_cnt, bus2.o_cnt_sat);
    end
  endtask

  task automatic test_gaps();
    int hits;
    hits = 0;
    do_reset();
    send1(1'b1); hits += int'(bus1.o_match);
    repeat (3) begin idle(1); hits += int'(bus1.o_match); end
    send1(1'b0); hits += int'(bus1.o_match);
    repeat (3) begin idle(1); hits += int'(bus1.o_match); end
    send1(1'b1); hits += int'(bus1.o_match);
    repeat (3) begin idle(1); hits += int'(bus1.o_match); end
    send1(1'b0);
    checks++;
    if (bus1.o_match !== 1'b1 || hits != 0) begin
      failures++;
      $display("FAIL gaps final=%b early_hits=%0d expected final=1 early_hits=0", bus1.o_match, hits);
    end
  endtask

  task automatic test_mid_pattern();
    do_reset();
    send1(1'b1); send1(1'b0); send1(1'b1);
    do_reset();
    send1(1'b0);
    checks++;
    if (bus1.o_match !== 1'b0 || bus1.o_armed !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset match/armed=%b%b expected=00", bus1.o_match, bus1.o_armed);
    end
    send1(1'b1); send1(1'b0); send1(1'b1); send1(1'b0);
    checks++;
    if (bus1.o_match !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_rematch got=%b expected=1", bus1.o_match);
    end
    do_reset();
    send1(1'b1); send1(1'b0); send1(1'b1);
    bus1.i_valid = 1'b1; bus1.i_bit = 1'b0;
    cfg1(4'b1010, 4'b1111, 1'b1);
    bus1.i_valid = 1'b0;
    checks++;
    if (bus1.o_match !== 1'b0 || bus1.o_armed !== 1'b0 || bus1.o_match_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cfg_coincident match=%b armed=%b cnt=%0d expected 0 0 0",
               bus1.o_match, bus1.o_armed, bus1.o_match_cnt);
    end
    send1(1'b0);
    checks++;
    if (bus1.o_match !== 1'b0) begin
      failures++;
      $display("FAIL cfg_history_cleared got=%b expected=0", bus1.o_match);
    end
  endtask

  initial begin
    bus1.i_valid = 1'b0; bus1.i_bit = 1'b0; bus1.i_cfg_wr = 1'b0; bus1.i_cfg_pattern = 4'b0000;
    bus1.i_cfg_mask = 4'b0000; bus1.i_cfg_overlap = 1'b0; bus1.i_cnt_clr = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_bit = 1'b0; bus2.i_cfg_wr = 1'b0; bus2.i_cfg_pattern = 4'b0000;
    bus2.i_cfg_mask = 4'b0000; bus2.i_cfg_overlap = 1'b0; bus2.i_cnt_clr = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_mask();
    test_counter_sat();
    test_gaps();
    test_mid_pattern();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
